// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the 4-digit 7-segment scan controller
package seg_pkg;

  // Number of multiplexed digits on the display
  localparam int NDIG = 4;

  // All segments off (active-low) and all digit enables off (active-low)
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns; element [n] is the glyph for nibble n
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low segment decoder
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered 4-digit 7-segment scan scheduler
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] SCAN_DIV  = 16'd12500,
  parameter logic [DIV_W-1:0] BLANK_CYC = 16'd250
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  input  logic       i_commit,
  input  logic       i_lzb,
  output logic       o_busy,
  output logic       o_frame,
  output logic [6:0] o_hex,
  output logic [3:0] o_dig
);

  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CNT_LAST = SCAN_DIV - CNT_ONE;

  logic [DIV_W-1:0]     r_cnt;
  logic [1:0]           r_idx;
  logic [NDIG-1:0][3:0] r_shadow;
  logic [NDIG-1:0][3:0] r_active;
  logic                 r_pending;
  logic [6:0]           r_hex;
  logic [3:0]           r_dig;
  logic                 r_frame;

  logic       w_slot_end;
  logic       w_boundary;
  logic       w_blank;
  logic       w_lz_blank;
  logic [3:0] w_nib;
  logic [6:0] w_seg;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == 2'd3);
  assign w_blank    = (r_cnt < BLANK_CYC);
  assign w_nib      = r_active[r_idx];

  // Leading zeros are judged on the committed store so blanking never tears mid-frame
  assign w_lz_blank = i_lzb && (
      ((r_idx == 2'd3) && (r_active[3] == 4'd0)) ||
      ((r_idx == 2'd2) && (r_active[3] == 4'd0) && (r_active[2] == 4'd0)) ||
      ((r_idx == 2'd1) && (r_active[3] == 4'd0) && (r_active[2] == 4'd0) &&
                          (r_active[1] == 4'd0)));

  seg7_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Slot prescaler and digit scan index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Shadow store accepts writes at any time, including while a commit is pending
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (i_wr_en) begin
      r_shadow[i_wr_addr] <= i_wr_data;
    end
  end

  // Pending commit copies the shadow into the active store only at a frame boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= i_commit;
    end else if (i_commit) begin
      r_pending <= 1'b1;
    end
  end

  // Registered display outputs: blank interval first, then the selected digit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hex   <= SEG_OFF;
      r_dig   <= DIG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (w_blank) begin
        r_hex <= SEG_OFF;
        r_dig <= DIG_OFF;
      end else begin
        r_dig <= ~(4'b0001 << r_idx);
        r_hex <= w_lz_blank ? SEG_OFF : w_seg;
      end
    end
  end

  assign o_busy  = r_pending;
  assign o_frame = r_frame;
  assign o_hex   = r_hex;
  assign o_dig   = r_dig;

endmodule
